// File: rtl/spike_aer_encoder.sv
// Serialises per-step spike vectors from a neuron bank into a buffered AER stream.
// Each spike becomes one {timestamp, address} event on a first-word-fall-through FIFO.
module spike_aer_encoder #(
    parameter int NUM_NEURONS = 8,
    parameter int TS_W        = 16,
    parameter int DEPTH       = 16,
    localparam int AW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample,
    input  logic [NUM_NEURONS-1:0] spikes,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [AW-1:0]          ev_addr,
    output logic [TS_W-1:0]        ev_ts,
    output logic                   busy,
    output logic [CW-1:0]          fifo_count,
    output logic                   overflow,
    output logic                   dbg_state
);
    // Handshake: an event transfers on a clock edge where ev_valid & ev_ready are both 1;
    // the head fields stay stable while ev_valid is high and ev_ready is low.

    typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_NEURONS-1:0] r_pending;
    logic [NUM_NEURONS-1:0] w_pending_clr;
    logic [TS_W-1:0]        r_ts;
    logic [TS_W-1:0]        r_ts_lat;
    logic                   r_overflow;
    logic [AW-1:0]          w_idx;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_can_push;

    logic [AW-1:0]          r_mem_addr [DEPTH];
    logic [TS_W-1:0]        r_mem_ts   [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;

    // x & (x-1) drops the lowest set bit, i.e. the neuron being emitted now.
    assign w_pending_clr = r_pending & (r_pending - NUM_NEURONS'(1));
    assign w_pop         = ev_valid & ev_ready;
    assign w_can_push    = (r_count != CW'(DEPTH)) | w_pop;

    always_comb begin
        w_idx = '0;
        for (int k = NUM_NEURONS - 1; k >= 0; k--) begin
            if (r_pending[k]) w_idx = AW'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (sample && (spikes != '0)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_can_push) begin
                    w_push = 1'b1;
                    if (w_pending_clr == '0) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_ts       <= '0;
            r_ts_lat   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (sample) r_ts <= r_ts + TS_W'(1);
            if (w_accept) begin
                r_pending <= spikes;
                r_ts_lat  <= r_ts;
            end else if (w_push) begin
                r_pending <= w_pending_clr;
            end
            // A sample arriving mid-scan is dropped; only lost spikes are flagged.
            if (sample && (r_state == SCAN) && (spikes != '0)) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= w_idx;
            r_mem_ts[r_wr_ptr]   <= r_ts_lat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign ev_valid   = (r_count != '0);
    assign ev_addr    = ev_valid ? r_mem_addr[r_rd_ptr] : '0;
    assign ev_ts      = ev_valid ? r_mem_ts[r_rd_ptr] : '0;
    assign busy       = (r_state == SCAN);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder: a default instance plus a TS_W=4 instance
// for timestamp wrap.
module tb_spike_aer_encoder;
    logic        clk;
    logic        rst;
    logic        sample;
    logic [7:0]  spikes;
    logic        ev_valid;
    logic        ev_ready;
    logic [2:0]  ev_addr;
    logic [15:0] ev_ts;
    logic        busy;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic        dbg_state;

    logic        sample4;
    logic [7:0]  spikes4;
    logic        ev_valid4;
    logic        ev_ready4;
    logic [2:0]  ev_addr4;
    logic [3:0]  ev_ts4;
    logic        busy4;
    logic [4:0]  fifo_count4;
    logic        overflow4;
    logic        dbg_state4;

    logic [18:0] exp_q[$];
    logic [15:0] m_ts;
    int          total;
    int          bad;

    spike_aer_encoder #(.NUM_NEURONS(8), .TS_W(16), .DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .sample(sample), .spikes(spikes),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_ts(ev_ts),
        .busy(busy), .fifo_count(fifo_count), .overflow(overflow), .dbg_state(dbg_state)
    );

    spike_aer_encoder #(.NUM_NEURONS(8), .TS_W(4), .DEPTH(16)) u_dut4 (
        .clk(clk), .rst(rst), .sample(sample4), .spikes(spikes4),
        .ev_valid(ev_valid4), .ev_ready(ev_ready4), .ev_addr(ev_addr4), .ev_ts(ev_ts4),
        .busy(busy4), .fifo_count(fifo_count4), .overflow(overflow4), .dbg_state(dbg_state4)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: one-cycle sample pulse; expected events pushed when the model accepts it
    task automatic do_sample(input logic [7:0] v, input bit accept);
        sample = 1'b1;
        spikes = v;
        tick();
        sample = 1'b0;
        spikes = '0;
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                if (v[k]) exp_q.push_back({m_ts, 3'(k)});
            end
        end
        m_ts = m_ts + 16'd1;
    endtask

    task automatic do_sample4(input logic [7:0] v);
        sample4 = 1'b1;
        spikes4 = v;
        tick();
        sample4 = 1'b0;
        spikes4 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample = 1'b0;
        spikes = '0;
        sample4 = 1'b0;
        spikes4 = '0;
        tick();
        tick();
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_head", {13'd0, ev_ts, ev_addr}, 0);
        rst = 1'b0;
        exp_q.delete();
        m_ts = '0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !ev_valid) break;
            tick();
        end
        chk("drain_left", 32'(exp_q.size()), 0);
        chk("drain_valid", 32'(ev_valid), 0);
    endtask

    task automatic expect4(input string tag, input logic [3:0] ts, input logic [2:0] addr);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (ev_valid4) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_seen"}, 32'(found), 1);
        chk({tag, "_ev"}, {25'd0, ev_ts4, ev_addr4}, {25'd0, ts, addr});
        tick();
        tick();
    endtask

    // scoreboard: compare every handshake against the expected queue
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            chk("ev_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("ev_data", {13'd0, ev_ts, ev_addr}, {13'd0, exp_q.pop_front()});
        end
    end

    initial begin
        total = 0;
        bad = 0;
        m_ts = '0;
        ev_ready = 1'b1;
        ev_ready4 = 1'b1;

        // 1: two spikes, latency and busy length
        do_reset();
        do_sample(8'b0000_0101, 1'b1);
        chk("t1_busy0", 32'(busy), 1);
        chk("t1_valid0", 32'(ev_valid), 0);
        tick();
        chk("t1_valid1", 32'(ev_valid), 1);
        chk("t1_busy1", 32'(busy), 1);
        tick();
        chk("t1_busy2", 32'(busy), 0);
        wait_drain(20);

        // 2: empty steps only advance the timestamp
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_sample(8'h00, 1'b1);
            chk("t2_idle", 32'(busy), 0);
        end
        do_sample(8'h80, 1'b1);
        wait_drain(20);

        // 3: fill FIFO, then stall scanner on full FIFO, then drain in order
        do_reset();
        ev_ready = 1'b0;
        do_sample(8'hFF, 1'b1);
        repeat (9) tick();
        do_sample(8'hFF, 1'b1);
        repeat (12) tick();
        chk("t3_count", 32'(fifo_count), 16);
        chk("t3_idle", 32'(busy), 0);
        chk("t3_head", {13'd0, ev_ts, ev_addr}, 0);
        do_sample(8'hFF, 1'b1);
        repeat (4) tick();
        chk("t3_stall", 32'(busy), 1);
        chk("t3_full", 32'(fifo_count), 16);
        chk("t3_ovf", 32'(overflow), 0);
        ev_ready = 1'b1;
        wait_drain(100);
        chk("t3_done", 32'(busy), 0);

        // 4: sample during scan is dropped and flagged, ts still advances
        do_reset();
        do_sample(8'hFF, 1'b1);
        tick();
        do_sample(8'h01, 1'b0);
        chk("t4_ovf", 32'(overflow), 1);
        wait_drain(40);
        do_sample(8'h02, 1'b1);
        wait_drain(20);
        chk("t4_ovf_sticky", 32'(overflow), 1);

        // 5: timestamp wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 15; i++) do_sample4(8'h00);
        do_sample4(8'h02);
        expect4("t5_ts15", 4'd15, 3'd1);
        do_sample4(8'h02);
        expect4("t5_ts0", 4'd0, 3'd1);
        chk("t5_ovf", 32'(overflow4), 0);

        // 6: reset in the middle of a scan
        do_reset();
        ev_ready = 1'b0;
        do_sample(8'hFF, 1'b1);
        do_sample(8'h01, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (fifo_count == 5'd3) break;
            tick();
        end
        chk("t6_count3", 32'(fifo_count), 3);
        chk("t6_ovf_pre", 32'(overflow), 1);
        rst = 1'b1;
        tick();
        chk("t6_valid", 32'(ev_valid), 0);
        chk("t6_count", 32'(fifo_count), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_ovf", 32'(overflow), 0);
        rst = 1'b0;
        exp_q.delete();
        m_ts = '0;
        ev_ready = 1'b1;
        do_sample(8'h01, 1'b1);
        wait_drain(20);

        chk("final_q", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
